// File: rtl/user_event_gen_pkg.sv
// Shared definitions for the user event stream: event codes, button
// indices and the per-button auto-repeat phase.
package user_event_gen_pkg;

   localparam logic [2:0] EV_NONE     = 3'd0;
   localparam logic [2:0] EV_LEFT     = 3'd1;
   localparam logic [2:0] EV_RIGHT    = 3'd2;
   localparam logic [2:0] EV_DOWN     = 3'd3;
   localparam logic [2:0] EV_ROTATE   = 3'd4;
   localparam logic [2:0] EV_NEW_GAME = 3'd5;

   localparam int BTN_LEFT     = 0;
   localparam int BTN_RIGHT    = 1;
   localparam int BTN_DOWN     = 2;
   localparam int BTN_ROTATE   = 3;
   localparam int BTN_NEW_GAME = 4;
   localparam int BTN_CNT      = 5;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   // Event code produced by a given button index.
   function automatic logic [2:0] btn_event(input int idx);
      case (idx)
         BTN_LEFT:     return EV_LEFT;
         BTN_RIGHT:    return EV_RIGHT;
         BTN_DOWN:     return EV_DOWN;
         BTN_ROTATE:   return EV_ROTATE;
         BTN_NEW_GAME: return EV_NEW_GAME;
         default:      return EV_NONE;
      endcase
   endfunction

endpackage

// File: rtl/user_event_fifo.sv
// Show-ahead FIFO: the head entry is read combinationally from storage.
// Pointers carry one extra wrap bit to tell full from empty. A push into a
// full FIFO is dropped unless a pop happens in the same cycle; a dropped
// push sets a sticky overflow flag.
module user_event_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic             overflow_reg;
   logic             pop_ok;
   logic             push_ok;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop_ok   = pop & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok  = push & (~full | pop_ok);
   assign dout     = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
   assign overflow = overflow_reg;

   // Storage write; contents need no reset since empty masks the head.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   // Pointer and sticky overflow update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (push && !push_ok) overflow_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/user_event_gen.sv
// Button front end: synchronise and debounce five buttons, turn press edges
// (plus auto-repeat on left/right/down) into event codes, and queue them.
module user_event_gen
   import user_event_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = 250000,
   parameter int REPEAT_DELAY_CYCLES  = 12500000,
   parameter int REPEAT_PERIOD_CYCLES = 2500000,
   parameter int FIFO_DEPTH           = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   btn_i,
   output logic [2:0]   event_o,
   output logic         event_ready_o,
   input  logic         event_rd_req_i,
   output logic         overflow_o
);

   localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int RCW = $clog2(RMX + 1);

   logic [BTN_CNT-1:0] sync1_reg, sync2_reg;
   logic [BTN_CNT-1:0] deb_level, deb_d_reg;
   logic [BTN_CNT-1:0] press, rpt_set, grant;
   logic [BTN_CNT-1:0] pending_reg, pending_next;
   logic               push;
   logic [2:0]         push_code;
   logic               fifo_empty, fifo_full;

   // Two-flop synchroniser and one-cycle delayed debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         deb_d_reg <= '0;
      end else begin
         sync1_reg <= btn_i;
         sync2_reg <= sync1_reg;
         deb_d_reg <= deb_level;
      end
   end

   assign press = deb_level & ~deb_d_reg;

   for (genvar gi = 0; gi < BTN_CNT; gi++) begin : g_btn
      logic [DCW-1:0] cnt_reg;
      logic           deb_bit_reg;

      // Debounce: accept a new level only after it has been stable long enough.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_reg     <= '0;
            deb_bit_reg <= 1'b0;
         end else if (sync2_reg[gi] != deb_bit_reg) begin
            if (cnt_reg == DCW'(DEBOUNCE_CYCLES - 1)) begin
               deb_bit_reg <= sync2_reg[gi];
               cnt_reg     <= '0;
            end else begin
               cnt_reg <= cnt_reg + DCW'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
      end

      assign deb_level[gi] = deb_bit_reg;

      if (gi <= BTN_DOWN) begin : g_rpt
         rpt_state_t     state_reg, state_next;
         logic [RCW-1:0] rcnt_reg, rcnt_next;
         logic           hit;

         // Repeat phase and hold counter register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg <= RPT_IDLE;
               rcnt_reg  <= '0;
            end else begin
               state_reg <= state_next;
               rcnt_reg  <= rcnt_next;
            end
         end

         // Repeat phase sequencing; release wins over a coinciding repeat tick.
         always_comb begin
            state_next = state_reg;
            rcnt_next  = rcnt_reg;
            hit        = 1'b0;
            case (state_reg)
               RPT_IDLE: begin
                  if (press[gi]) begin
                     state_next = RPT_DELAY;
                     rcnt_next  = '0;
                  end
               end
               RPT_DELAY: begin
                  if (!deb_level[gi]) begin
                     state_next = RPT_IDLE;
                     rcnt_next  = '0;
                  end else if (rcnt_reg == RCW'(REPEAT_DELAY_CYCLES - 1)) begin
                     hit        = 1'b1;
                     state_next = RPT_REPEAT;
                     rcnt_next  = '0;
                  end else begin
                     rcnt_next = rcnt_reg + RCW'(1);
                  end
               end
               RPT_REPEAT: begin
                  if (!deb_level[gi]) begin
                     state_next = RPT_IDLE;
                     rcnt_next  = '0;
                  end else if (rcnt_reg == RCW'(REPEAT_PERIOD_CYCLES - 1)) begin
                     hit        = 1'b1;
                     rcnt_next  = '0;
                  end else begin
                     rcnt_next = rcnt_reg + RCW'(1);
                  end
               end
               default: begin
                  state_next = RPT_IDLE;
                  rcnt_next  = '0;
               end
            endcase
         end

         assign rpt_set[gi] = hit;
      end else begin : g_no_rpt
         assign rpt_set[gi] = 1'b0;
      end
   end

   // Fixed-priority arbiter: one push per cycle, new_game first.
   always_comb begin
      grant     = '0;
      push_code = EV_NONE;
      if (pending_reg[BTN_NEW_GAME])    grant[BTN_NEW_GAME] = 1'b1;
      else if (pending_reg[BTN_ROTATE]) grant[BTN_ROTATE]   = 1'b1;
      else if (pending_reg[BTN_LEFT])   grant[BTN_LEFT]     = 1'b1;
      else if (pending_reg[BTN_RIGHT])  grant[BTN_RIGHT]    = 1'b1;
      else if (pending_reg[BTN_DOWN])   grant[BTN_DOWN]     = 1'b1;
      for (int i = 0; i < BTN_CNT; i++) begin
         if (grant[i]) push_code = btn_event(i);
      end
   end

   assign push         = |grant;
   // The winner clears even if the FIFO drops it; new sets always win.
   assign pending_next = press | rpt_set | (pending_reg & ~grant);

   // Pending flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending_reg <= '0;
      else     pending_reg <= pending_next;
   end

   user_event_fifo #(
      .WIDTH (3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .din      (push_code),
      .pop      (event_rd_req_i),
      .dout     (event_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (overflow_o)
   );

   assign event_ready_o = ~fifo_empty;

endmodule

// File: tb/tb_user_event_gen.sv
// Directed testbench for user_event_gen with short debounce/repeat timing.
module tb_user_event_gen;
   import user_event_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn_i;
   logic [2:0] event_o;
   logic       event_ready_o;
   logic       event_rd_req_i;
   logic       overflow_o;

   int n_cmp  = 0;
   int n_fail = 0;

   user_event_gen #(
      .DEBOUNCE_CYCLES      (4),
      .REPEAT_DELAY_CYCLES  (20),
      .REPEAT_PERIOD_CYCLES (8),
      .FIFO_DEPTH           (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_i          (btn_i),
      .event_o        (event_o),
      .event_ready_o  (event_ready_o),
      .event_rd_req_i (event_rd_req_i),
      .overflow_o     (overflow_o)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
   endtask

   // Check the head entry, then pop it.
   task automatic pop_expect(input logic [2:0] code, input string name);
      n_cmp++;
      if (event_ready_o !== 1'b1 || event_o !== code) begin
         n_fail++;
         $display("FAIL %s: ready=%b event=%0d, required ready=1 event=%0d",
                  name, event_ready_o, event_o, code);
      end else begin
         $display("pop %s: event=%0d", name, event_o);
      end
      event_rd_req_i = 1'b1;
      step();
      event_rd_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_i = '0; event_rd_req_i = 1'b0;
      repeat (2) step();
      n_cmp++;
      if (event_ready_o !== 1'b0 || event_o !== 3'd0 || overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b event=%0d ovf=%b, required 0/0/0",
                  event_ready_o, event_o, overflow_o);
      end else $display("reset_state ok");
      rst = 1'b0;
      step();
   endtask

   task automatic test_glitch_single();
      bit seen = 0;
      btn_i[BTN_ROTATE] = 1'b1;
      repeat (3) step();
      btn_i[BTN_ROTATE] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (event_ready_o) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++;
         $display("FAIL glitch: ready seen=1, required 0");
      end else $display("glitch rejected");

      btn_i[BTN_ROTATE] = 1'b1;
      repeat (7) step();
      n_cmp++;
      if (event_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rotate_early: ready=%b at cycle 7, required 0", event_ready_o);
      end
      step();
      n_cmp++;
      if (event_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rotate_latency: ready=%b at cycle 8, required 1", event_ready_o);
      end else $display("rotate ready at cycle 8");
      pop_expect(EV_ROTATE, "rotate");
      seen = 0;
      for (int c = 0; c < 41; c++) begin
         if (event_ready_o) seen = 1;
         step();
      end
      btn_i[BTN_ROTATE] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (event_ready_o) seen = 1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++;
         $display("FAIL rotate_repeat: extra event seen, required none");
      end else $display("rotate no repeat");
   endtask

   task automatic test_auto_repeat();
      int exp_cyc [6] = '{8, 28, 36, 44, 52, 60};
      int cyc_q [$];
      logic [2:0] code_q [$];
      btn_i[BTN_LEFT] = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         step();
         if (c == 60) btn_i[BTN_LEFT] = 1'b0;
         if (event_ready_o) begin
            cyc_q.push_back(c);
            code_q.push_back(event_o);
            event_rd_req_i = 1'b1;
         end else begin
            event_rd_req_i = 1'b0;
         end
      end
      event_rd_req_i = 1'b0;
      n_cmp++;
      if (cyc_q.size() != 6) begin
         n_fail++;
         $display("FAIL repeat_count: events=%0d, required 6", cyc_q.size());
      end else $display("repeat count 6");
      for (int i = 0; i < 6 && i < cyc_q.size(); i++) begin
         n_cmp++;
         if (cyc_q[i] != exp_cyc[i] || code_q[i] !== EV_LEFT) begin
            n_fail++;
            $display("FAIL repeat_ev%0d: cycle=%0d code=%0d, required cycle=%0d code=%0d",
                     i, cyc_q[i], code_q[i], exp_cyc[i], EV_LEFT);
         end else $display("repeat ev%0d at cycle %0d", i, cyc_q[i]);
      end
   endtask

   task automatic test_handshake_empty();
      event_rd_req_i = 1'b1;
      repeat (6) step();
      n_cmp++;
      if (event_ready_o !== 1'b0 || event_o !== 3'd0) begin
         n_fail++;
         $display("FAIL rd_empty: ready=%b event=%0d, required 0/0", event_ready_o, event_o);
      end else $display("rd_req while empty ignored");
      event_rd_req_i = 1'b0;
      btn_i[BTN_RIGHT] = 1'b1;
      repeat (10) step();
      btn_i[BTN_RIGHT] = 1'b0;
      pop_expect(EV_RIGHT, "after_empty_rd");
      repeat (10) step();
      n_cmp++;
      if (event_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_empty_drain: ready=%b, required 0", event_ready_o);
      end
   endtask

   task automatic press_release(input int b);
      btn_i[b] = 1'b1;
      repeat (10) step();
      btn_i[b] = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_full_push_pop();
      press_release(BTN_ROTATE);
      press_release(BTN_LEFT);
      press_release(BTN_RIGHT);
      press_release(BTN_DOWN);
      n_cmp++;
      if (event_ready_o !== 1'b1 || event_o !== EV_ROTATE || overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_head: ready=%b event=%0d ovf=%b, required 1/%0d/0",
                  event_ready_o, event_o, overflow_o, EV_ROTATE);
      end else $display("four entries queued");
      btn_i[BTN_NEW_GAME] = 1'b1;
      repeat (7) step();
      event_rd_req_i = 1'b1;
      step();
      event_rd_req_i = 1'b0;
      n_cmp++;
      if (overflow_o !== 1'b0 || event_ready_o !== 1'b1 || event_o !== EV_LEFT) begin
         n_fail++;
         $display("FAIL full_push_pop: ovf=%b ready=%b event=%0d, required 0/1/%0d",
                  overflow_o, event_ready_o, event_o, EV_LEFT);
      end else $display("push+pop while full accepted");
      repeat (5) step();
      btn_i[BTN_NEW_GAME] = 1'b0;
      repeat (12) step();
      pop_expect(EV_LEFT, "fpp_1");
      pop_expect(EV_RIGHT, "fpp_2");
      pop_expect(EV_DOWN, "fpp_3");
      pop_expect(EV_NEW_GAME, "fpp_4");
      n_cmp++;
      if (event_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fpp_empty: ready=%b, required 0", event_ready_o);
      end
   endtask

   task automatic test_arbitration_and_reset();
      btn_i = 5'b11111;
      repeat (11) step();
      n_cmp++;
      if (overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_ovf_early: ovf=%b at cycle 11, required 0", overflow_o);
      end
      step();
      n_cmp++;
      if (overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL arb_overflow: ovf=%b at cycle 12, required 1", overflow_o);
      end else $display("down dropped, overflow set");
      repeat (3) step();
      btn_i = '0;
      pop_expect(EV_NEW_GAME, "arb_0");
      pop_expect(EV_ROTATE, "arb_1");
      n_cmp++;
      if (event_ready_o !== 1'b1 || event_o !== EV_LEFT || overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL arb_remaining: ready=%b event=%0d ovf=%b, required 1/%0d/1",
                  event_ready_o, event_o, overflow_o, EV_LEFT);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (event_ready_o !== 1'b0 || overflow_o !== 1'b0 || event_o !== 3'd0) begin
         n_fail++;
         $display("FAIL async_reset: ready=%b ovf=%b event=%0d, required 0/0/0",
                  event_ready_o, overflow_o, event_o);
      end else $display("async reset cleared FIFO and overflow");
      repeat (2) step();
      rst = 1'b0;
      repeat (10) step();
      n_cmp++;
      if (event_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: ready=%b, required 0", event_ready_o);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         btn_i[BTN_RIGHT] = 1'b1;
         repeat (10) step();
         btn_i[BTN_RIGHT] = 1'b0;
         pop_expect(EV_RIGHT, $sformatf("wrap_%0d", i));
         repeat (10) step();
      end
      n_cmp++;
      if (event_ready_o !== 1'b0 || overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_end: ready=%b ovf=%b, required 0/0", event_ready_o, overflow_o);
      end else $display("wrap done, FIFO empty");
   endtask

   initial begin
      test_reset();
      test_glitch_single();
      test_auto_repeat();
      test_handshake_empty();
      test_full_push_pop();
      test_arbitration_and_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
